dnoc_dma_rd_sched: RTL

DNOC_DMA_RD_SCHED -- requirements
Module: dnoc_dma_rd_sched

---
 rtl/dnoc_pkg.sv | 30 +++
 rtl/dnoc_rr_arb2.sv | 36 +++
 rtl/dnoc_dma_rd_sched.sv | 117 +++++++++++
 3 files changed

// File: rtl/dnoc_pkg.sv
// Shared types for the DNoC DMA read-command path.
// Holds the read cfg bundle and the scheduler state encoding.
package dnoc_pkg;

  localparam int unsigned DMA_AW = 13;

  typedef struct packed {
    logic [1:0][DMA_AW-1:0] base_addr;
    logic [DMA_AW-1:0]      ping_lenth;
    logic [DMA_AW-1:0]      pong_lenth;
    logic [11:0]            noc_mc_scale;
    logic                   req_sel;
    logic                   pingpong_en;
    logic [10:0]            pingpong_num;
    logic [3:0][DMA_AW-1:0] loop_lenth;
    logic [3:0][DMA_AW-1:0] loop_gap;
  } dma_rd_cfg_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } rd_state_e;

  typedef enum logic {
    SRC_NOC  = 1'b0,
    SRC_CORE = 1'b1
  } rd_src_e;

endpackage

// File: rtl/dnoc_rr_arb2.sv
// Two-way round-robin arbiter with grant enable.
// Bit 0 is the NoC requester, bit 1 the core requester.
module dnoc_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  logic       r_ptr;
  logic [1:0] w_gnt;

  // r_ptr=1 means the core side wins the next tie
  always_comb begin
    w_gnt = 2'b00;
    if (i_en) begin
      if (i_req == 2'b11) begin
        w_gnt = r_ptr ? 2'b10 : 2'b01;
      end else begin
        w_gnt = i_req;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 1'b0;
    end else if (|w_gnt) begin
      r_ptr <= w_gnt[0];
    end
  end

  assign o_gnt = w_gnt;

endmodule

// File: rtl/dnoc_dma_rd_sched.sv
// DMA read-command scheduler: arbitrates NoC and core requests,
// issues one command at a time and routes completion back.
module dnoc_dma_rd_sched
  import dnoc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             noc_rd_req,
  output logic             noc_rd_gnt,
  input  dma_rd_cfg_t      noc_rd_cfg,
  input  logic             core_rd_req,
  output logic             core_rd_gnt,
  input  dma_rd_cfg_t      core_rd_cfg,
  output logic             dma_rd_valid,
  input  logic             dma_rd_ready,
  output dma_rd_cfg_t      dma_rd_cfg,
  output logic             dma_rd_src,
  input  logic             dma_rd_done,
  output logic             noc_rd_done,
  output logic             core_rd_done,
  output logic             busy,
  output logic             err_spurious_done,
  output logic [CNT_W-1:0] noc_gnt_cnt,
  output logic [CNT_W-1:0] core_gnt_cnt
);

  rd_state_e        r_state;
  dma_rd_cfg_t      r_cfg;
  logic             r_src;
  logic             r_err;
  logic [CNT_W-1:0] r_noc_cnt;
  logic [CNT_W-1:0] r_core_cnt;

  logic       w_arb_en;
  logic [1:0] w_gnt;
  logic       w_done_ok;

  // gating with rst_n keeps grants low while reset is held
  assign w_arb_en = rst_n && (r_state == ST_IDLE);

  dnoc_rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_arb_en),
    .i_req ({core_rd_req, noc_rd_req}),
    .o_gnt (w_gnt)
  );

  assign w_done_ok = (r_state == ST_WAIT_DONE) && dma_rd_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cfg   <= '0;
      r_src   <= SRC_NOC;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (|w_gnt) begin
            r_cfg   <= w_gnt[1] ? core_rd_cfg : noc_rd_cfg;
            r_src   <= w_gnt[1];
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (dma_rd_ready) begin
            r_state <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (dma_rd_done) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // a done outside WAIT_DONE (incl. same cycle as ready) is an error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (dma_rd_done && !w_done_ok) begin
      r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_noc_cnt  <= '0;
      r_core_cnt <= '0;
    end else begin
      if (w_gnt[0] && (r_noc_cnt != '1)) begin
        r_noc_cnt <= r_noc_cnt + CNT_W'(1);
      end
      if (w_gnt[1] && (r_core_cnt != '1)) begin
        r_core_cnt <= r_core_cnt + CNT_W'(1);
      end
    end
  end

  assign noc_rd_gnt        = w_gnt[0];
  assign core_rd_gnt       = w_gnt[1];
  assign dma_rd_valid      = (r_state == ST_ISSUE);
  assign dma_rd_cfg        = r_cfg;
  assign dma_rd_src        = r_src;
  assign noc_rd_done       = w_done_ok && (r_src == SRC_NOC);
  assign core_rd_done      = w_done_ok && (r_src == SRC_CORE);
  assign busy              = (r_state != ST_IDLE);
  assign err_spurious_done = r_err;
  assign noc_gnt_cnt       = r_noc_cnt;
  assign core_gnt_cnt      = r_core_cnt;

endmodule
